// File: rtl/gray_counter.sv
// gray_counter
//   Up/down counter whose state is held natively in Gray code. Binary and
//   Gray views are both registered. q_gray_o comes straight from the Gray
//   flops, so it is safe to sample in another clock domain: each counting
//   step changes exactly one bit.
//
// Parameters
//   WIDTH        counter width in bits (>= 2)
//   SATURATE     0: wrap modulo 2**WIDTH, 1: hold at 0 / 2**WIDTH-1
//   RESET_VALUE  binary value applied on rst_i and clear_i
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous reset, active-high
//   clear_i   synchronous clear to RESET_VALUE (highest priority)
//   load_i    synchronous load of d_i
//   d_i       binary load value
//   en_i      count enable, one step per cycle
//   down_i    direction when en_i=1: 0 counts up, 1 counts down
//   q_bin_o   registered binary count
//   q_gray_o  registered Gray count, always bin ^ (bin >> 1)
//   wrap_o    registered one-cycle pulse on a wrap or blocked saturating step
module gray_counter #(
  parameter int unsigned      WIDTH       = 9,
  parameter bit               SATURATE    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] q_bin_o,
  output logic [WIDTH-1:0] q_gray_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX_VALUE = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  function automatic logic [WIDTH-1:0] binary_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic logic [WIDTH-1:0] gray_to_binary(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_q;
  logic             wrap_q;

  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;
  logic             at_top;
  logic             at_bottom;

  // The arithmetic works from the Gray state itself, so the binary copy
  // is purely an output register and never feeds back.
  assign cur_bin   = gray_to_binary(gray_q);
  assign at_top    = (cur_bin == MAX_VALUE);
  assign at_bottom = (cur_bin == '0);

  always_comb begin
    next_bin  = cur_bin;
    next_wrap = 1'b0;
    if (clear_i) begin
      next_bin = RESET_VALUE;
    end else if (load_i) begin
      next_bin = d_i;
    end else if (en_i) begin
      if (!down_i) begin
        if (at_top) begin
          next_wrap = 1'b1;
          if (!SATURATE) begin
            next_bin = '0;
          end
        end else begin
          next_bin = cur_bin + ONE;
        end
      end else begin
        if (at_bottom) begin
          next_wrap = 1'b1;
          if (!SATURATE) begin
            next_bin = MAX_VALUE;
          end
        end else begin
          next_bin = cur_bin - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gray_q <= binary_to_gray(RESET_VALUE);
      bin_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      gray_q <= binary_to_gray(next_bin);
      bin_q  <= next_bin;
      wrap_q <= next_wrap;
    end
  end

  assign q_gray_o = gray_q;
  assign q_bin_o  = bin_q;
  assign wrap_o   = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  localparam int W   = 9;
  localparam int MOD = 1 << W;
  localparam int MAXV = MOD - 1;
  localparam int RV  = 0;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clear_i = 1'b0;
  logic         load_i = 1'b0;
  logic [W-1:0] d_i = '0;
  logic         en_i = 1'b0;
  logic         down_i = 1'b0;

  logic [W-1:0] bin_w, gray_w, bin_s, gray_s;
  logic         wrap_w, wrap_s;

  gray_counter #(.WIDTH(W), .SATURATE(1'b0), .RESET_VALUE(9'(RV))) dut_w (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i),
    .d_i(d_i), .en_i(en_i), .down_i(down_i),
    .q_bin_o(bin_w), .q_gray_o(gray_w), .wrap_o(wrap_w)
  );

  gray_counter #(.WIDTH(W), .SATURATE(1'b1), .RESET_VALUE(9'(RV))) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .load_i(load_i),
    .d_i(d_i), .en_i(en_i), .down_i(down_i),
    .q_bin_o(bin_s), .q_gray_o(gray_s), .wrap_o(wrap_s)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers for the wrapping and saturating counters.
  int m_w = RV, m_s = RV;
  int e_wrap_w = 0, e_wrap_s = 0;

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Prefix-XOR by doubling shifts, good for widths up to 16.
  function automatic int bin_of_gray(input int g);
    int b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    return b;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " w_bin"},  int'(bin_w),  m_w);
    check({tag, " w_gray"}, int'(gray_w), gray_of(m_w));
    check({tag, " w_wrap"}, int'(wrap_w), e_wrap_w);
    check({tag, " w_g2b"},  bin_of_gray(int'(gray_w)), int'(bin_w));
    check({tag, " s_bin"},  int'(bin_s),  m_s);
    check({tag, " s_gray"}, int'(gray_s), gray_of(m_s));
    check({tag, " s_wrap"}, int'(wrap_s), e_wrap_s);
    check({tag, " s_g2b"},  bin_of_gray(int'(gray_s)), int'(bin_s));
  endtask

  task automatic model(input bit c, input bit l, input int d, input bit e, input bit dn);
    e_wrap_w = 0;
    e_wrap_s = 0;
    if (c) begin
      m_w = RV;
      m_s = RV;
    end else if (l) begin
      m_w = d;
      m_s = d;
    end else if (e) begin
      e_wrap_w = (!dn && m_w == MAXV) || (dn && m_w == 0);
      m_w = dn ? (m_w + MOD - 1) % MOD : (m_w + 1) % MOD;
      if ((!dn && m_s == MAXV) || (dn && m_s == 0)) e_wrap_s = 1;
      else m_s = dn ? m_s - 1 : m_s + 1;
    end
  endtask

  int wrap_seen;

  // Drives controls just after an edge, clocks once, then checks at edge+1.
  task automatic step(input string tag, input bit c, input bit l, input int d,
                      input bit e, input bit dn);
    int  pg_w, pg_s;
    bit  cnt_w, cnt_s;
    clear_i = c;
    load_i  = l;
    d_i     = W'(d);
    en_i    = e;
    down_i  = dn;
    pg_w  = int'(gray_w);
    pg_s  = int'(gray_s);
    cnt_w = !c && !l && e;
    cnt_s = cnt_w && !((!dn && m_s == MAXV) || (dn && m_s == 0));
    @(posedge clk_i);
    model(c, l, d, e, dn);
    #1;
    check_all(tag);
    if (wrap_w) wrap_seen++;
    if (cnt_w) check({tag, " w_onebit"}, $countones(int'(gray_w) ^ pg_w), 1);
    if (cnt_s) check({tag, " s_onebit"}, $countones(int'(gray_s) ^ pg_s), 1);
  endtask

  initial begin
    // Reset state, asserted from time zero across the first edge.
    #3;
    check_all("reset");
    #4 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // 1: count up 1024 cycles from 0.
    wrap_seen = 0;
    for (int i = 0; i < 1024; i++) step("t1_up", 0, 0, 0, 1, 0);
    check("t1 wrap_count", wrap_seen, 2);
    check("t1 final_bin", int'(bin_w), 0);

    // 2: down from 0 for 512 cycles.
    step("t2_clear", 1, 0, 0, 0, 0);
    wrap_seen = 0;
    for (int i = 0; i < 512; i++) step("t2_down", 0, 0, 0, 1, 1);
    check("t2 wrap_count", wrap_seen, 1);
    check("t2 final_bin", int'(bin_w), 0);

    // 3: saturation at both ends.
    step("t3_load_top", 0, 1, MAXV, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("t3_sat_up", 0, 0, 0, 1, 0);
      check("t3 s_gray_top", int'(gray_s), 'h100);
      check("t3 s_wrap_top", int'(wrap_s), 1);
    end
    step("t3_leave_top", 0, 0, 0, 1, 1);
    check("t3 s_bin_510", int'(bin_s), 510);
    step("t3_load_bot", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("t3_sat_down", 0, 0, 0, 1, 1);
      check("t3 s_wrap_bot", int'(wrap_s), 1);
    end
    step("t3_leave_bot", 0, 0, 0, 1, 0);
    check("t3 s_bin_1", int'(bin_s), 1);

    // 4: load pattern, then clear beats load and enable.
    step("t4_load", 0, 1, 'h155, 0, 0);
    check("t4 gray_155", int'(gray_w), 'h1FF);
    step("t4_clear_wins", 1, 1, 'h0AA, 1, 0);
    check("t4 bin_rv", int'(bin_w), RV);

    // 5: asynchronous reset mid-cycle with count at 0x0A7.
    step("t5_load", 0, 1, 'h0A6, 0, 0);
    step("t5_to_a7", 0, 0, 0, 1, 0);
    check("t5 at_a7", int'(bin_w), 'h0A7);
    #2 rst_i = 1'b1;
    m_w = RV; m_s = RV; e_wrap_w = 0; e_wrap_s = 0;
    #0.5;
    check_all("t5_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i);
      #1;
      check_all("t5_hold");
    end
    #2 rst_i = 1'b0;
    #1;
    step("t5_resume", 0, 0, 0, 1, 0);
    check("t5 resume_bin", int'(bin_w), RV + 1);

    // 6: random controls against the model.
    for (int i = 0; i < 10000; i++) begin
      step("t6_rand",
           ($urandom_range(63) == 0),
           ($urandom_range(15) == 0),
           int'($urandom_range(MAXV)),
           ($urandom_range(3) != 0),
           1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: observed=stalled expected=finished");
    $fatal(1, "timeout");
  end

endmodule
